// File: rtl/ram_arbiter_pkg.sv
// Shared widths, the owner encoding and the debug view of the two-master RAM arbiter.
package ram_arbiter_pkg;

    localparam int ARB_ADDR_W     = 32;
    localparam int ARB_DATA_W     = 32;
    localparam int ARB_SEL_W      = 4;
    localparam int ARB_STARVE_LIM = 4;
    localparam int STARVE_W       = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    typedef struct packed {
        owner_e              owner;
        logic [STARVE_W-1:0] starve_cnt;
        logic                force_m1;
    } arb_dbg_t;

    function automatic owner_e owner_of(input logic g0, input logic g1);
        owner_e o;
        o = OWN_NONE;
        if (g0) begin
            o = OWN_M0;
        end else if (g1) begin
            o = OWN_M1;
        end
        return o;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// One master port of the RAM arbiter, seen from the master (master) or the arbiter (slave).
// Handshake: the master raises req with we/addr/sel/wdata and holds them until gnt is high in
// the same cycle; that edge issues the access. A granted read returns rdata with rvalid high for
// exactly the following cycle. Dropping req before gnt is legal and issues nothing.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int SEL_W  = ARB_SEL_W
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              stall;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, sel, wdata,
        input  gnt, stall, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, sel, wdata,
        output gnt, stall, rvalid, rdata
    );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of m0 wins taken while m1 was waiting; force_m1 hands the next
// contested slot to m1 once the count reaches the limit.
module arb_starve_cnt
    import ram_arbiter_pkg::*;
#(
    parameter int LIM = ARB_STARVE_LIM
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    output logic [STARVE_W-1:0] cnt,
    output logic                force_m1
);

    localparam logic [STARVE_W-1:0] LIM_C = STARVE_W'(LIM);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    // Clear wins over increment: an m1 grant or an idle m1 ends the starvation run.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIM_C)) begin
            cnt_d = cnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign force_m1 = (cnt_q == LIM_C);

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between m0 (CPU data port, priority) and m1 (DMA/debug),
// issuing at most one access per cycle and returning registered read data to the winner.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int SEL_W      = ARB_SEL_W,
    parameter int STARVE_LIM = ARB_STARVE_LIM
) (
    input  logic              clk,
    input  logic              rst,
    ram_arbiter_if.slave      m0,
    ram_arbiter_if.slave      m1,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [SEL_W-1:0]  ram_sel,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output arb_dbg_t          dbg
);

    logic                m0_gnt;
    logic                m1_gnt;
    logic                force_m1;
    logic [STARVE_W-1:0] starve_cnt;

    owner_e              owner_q;
    owner_e              owner_d;
    logic                m0_rvalid_q;
    logic                m0_rvalid_d;
    logic                m1_rvalid_q;
    logic                m1_rvalid_d;
    logic [DATA_W-1:0]   m0_rdata_q;
    logic [DATA_W-1:0]   m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q;
    logic [DATA_W-1:0]   m1_rdata_d;

    // No access is issued while reset is asserted, so nothing reaches the RAM mid-reset.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst) begin
            if (m0.req && m1.req) begin
                if (force_m1) begin
                    m1_gnt = 1'b1;
                end else begin
                    m0_gnt = 1'b1;
                end
            end else if (m0.req) begin
                m0_gnt = 1'b1;
            end else if (m1.req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_sel   = '0;
        ram_wdata = '0;
        if (m0_gnt) begin
            ram_ce    = 1'b1;
            ram_we    = m0.we;
            ram_addr  = m0.addr;
            ram_sel   = m0.sel;
            ram_wdata = m0.wdata;
        end else if (m1_gnt) begin
            ram_ce    = 1'b1;
            ram_we    = m1.we;
            ram_addr  = m1.addr;
            ram_sel   = m1.sel;
            ram_wdata = m1.wdata;
        end
    end

    arb_starve_cnt #(
        .LIM (STARVE_LIM)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (m0_gnt & m1.req),
        .clr      (m1_gnt | ~m1.req),
        .cnt      (starve_cnt),
        .force_m1 (force_m1)
    );

    // rdata only moves on a read for that master; otherwise it keeps the last read value.
    always_comb begin
        owner_d     = owner_of(m0_gnt, m1_gnt);
        m0_rvalid_d = m0_gnt & ~m0.we;
        m1_rvalid_d = m1_gnt & ~m1.we;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        if (m0_rvalid_d) begin
            m0_rdata_d = ram_rdata;
        end
        if (m1_rvalid_d) begin
            m1_rdata_d = ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q     <= OWN_NONE;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            owner_q     <= owner_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    assign m0.gnt    = m0_gnt;
    assign m0.stall  = m0.req & ~m0_gnt;
    assign m0.rvalid = m0_rvalid_q;
    assign m0.rdata  = m0_rdata_q;

    assign m1.gnt    = m1_gnt;
    assign m1.stall  = m1.req & ~m1_gnt;
    assign m1.rvalid = m1_rvalid_q;
    assign m1.rdata  = m1_rdata_q;

    always_comb begin
        dbg            = '0;
        dbg.owner      = owner_q;
        dbg.starve_cnt = starve_cnt;
        dbg.force_m1   = force_m1;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations, then random two-master
// traffic, all checked every cycle against a behavioural model with its own shadow memory.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if m0_if ();
    ram_arbiter_if m1_if ();

    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    arb_dbg_t    dbg;

    ram_arbiter #(.STARVE_LIM(LIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if),
        .m1        (m1_if),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_sel   (ram_sel),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    ,   .dbg       (dbg)
    );

    // Bench-side RAM: combinational read, byte-lane write at the clock edge.
    logic [31:0] ram_mem [256];
    assign ram_rdata = ram_mem[ram_addr[9:2]];
    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_sel[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mdl_mem [256];
    int          mdl_wait_run;
    logic        mdl_rv0, mdl_rv1;
    logic [31:0] mdl_rd0, mdl_rd1;
    logic [1:0]  mdl_owner;
    bit          chk_en = 1'b0;

    task automatic compare_cycle();
        int          win;
        int          idx;
        logic        e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_sel;
        if (!rst) begin
            mdl_wait_run = 0;
            mdl_rv0 = 1'b0;  mdl_rv1 = 1'b0;
            mdl_rd0 = '0;    mdl_rd1 = '0;
            mdl_owner = 2'b00;
        end
        win = -1;
        if (rst) begin
            if (m0_if.req && m1_if.req) win = (mdl_wait_run >= LIM) ? 1 : 0;
            else if (m0_if.req)         win = 0;
            else if (m1_if.req)         win = 1;
        end
        e_we = 1'b0; e_addr = '0; e_sel = '0; e_wdata = '0;
        if (win == 0) begin
            e_we = m0_if.we; e_addr = m0_if.addr; e_sel = m0_if.sel; e_wdata = m0_if.wdata;
        end else if (win == 1) begin
            e_we = m1_if.we; e_addr = m1_if.addr; e_sel = m1_if.sel; e_wdata = m1_if.wdata;
        end
        check("m0_gnt",    32'(m0_if.gnt),    32'(win == 0));
        check("m1_gnt",    32'(m1_if.gnt),    32'(win == 1));
        check("m0_stall",  32'(m0_if.stall),  32'(m0_if.req && win != 0));
        check("ram_ce",    32'(ram_ce),       32'(win >= 0));
        check("ram_we",    32'(ram_we),       32'(e_we));
        check("ram_addr",  ram_addr,          e_addr);
        check("ram_sel",   32'(ram_sel),      32'(e_sel));
        check("ram_wdata", ram_wdata,         e_wdata);
        check("m0_rvalid", 32'(m0_if.rvalid), 32'(mdl_rv0));
        check("m1_rvalid", 32'(m1_if.rvalid), 32'(mdl_rv1));
        check("m0_rdata",  m0_if.rdata,       mdl_rd0);
        check("m1_rdata",  m1_if.rdata,       mdl_rd1);
        check("dbg_owner", 32'(dbg.owner),    32'(mdl_owner));
        check("dbg_starve", 32'(dbg.starve_cnt), 32'(mdl_wait_run));
        check("dbg_force", 32'(dbg.force_m1), 32'(mdl_wait_run >= LIM));
        if (rst) begin
            idx = int'(e_addr[9:2]);
            mdl_rv0 = (win == 0) && !e_we;
            mdl_rv1 = (win == 1) && !e_we;
            if (mdl_rv0) mdl_rd0 = mdl_mem[idx];
            if (mdl_rv1) mdl_rd1 = mdl_mem[idx];
            if (win >= 0 && e_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (e_sel[b]) mdl_mem[idx][8*b +: 8] = e_wdata[8*b +: 8];
                end
            end
            if (win == 1 || !m1_if.req)  mdl_wait_run = 0;
            else if (win == 0)           mdl_wait_run = (mdl_wait_run + 1 > LIM) ? LIM : mdl_wait_run + 1;
            mdl_owner = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        if (chk_en) compare_cycle();
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata);
        m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.sel = sel; m0_if.wdata = wdata;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata);
        m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.sel = sel; m1_if.wdata = wdata;
    endtask

    task automatic idle();
        set_m0(1'b0, 1'b0, '0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    bit   exp_cont[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bit   exp_drop[13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    bit   busy0, busy1, got0, got1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = '0;
            mdl_mem[i] = '0;
        end
        idle();
        #1 rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) tick();
        #2 check("reset_rvalid0", 32'(m0_if.rvalid), 32'h0);
        check("reset_owner", 32'(dbg.owner), 32'h0);
        tick();
        rst = 1'b1;

        // A read granted just before reset is dropped.
        tick(); set_m0(1'b1, 1'b0, 32'h10, 4'hF, '0);
        #2 check("rmr_gnt", 32'(m0_if.gnt), 32'h1);
        #1 rst = 1'b0;
        tick(); idle();
        #2 check("rmr_rvalid", 32'(m0_if.rvalid), 32'h0);
        check("rmr_ram_ce", 32'(ram_ce), 32'h0);
        check("rmr_rdata", m0_if.rdata, 32'h0);
        tick(); rst = 1'b1;

        // Single write then read.
        tick(); set_m0(1'b1, 1'b1, 32'h20, 4'hF, 32'hDEADBEEF);
        #2 check("wr_gnt_same_cycle", 32'(m0_if.gnt), 32'h1);
        tick(); set_m0(1'b1, 1'b0, 32'h20, 4'hF, '0);
        tick(); idle();
        #2 check("rd_rvalid", 32'(m0_if.rvalid), 32'h1);
        check("rd_rdata", m0_if.rdata, 32'hDEADBEEF);
        tick();
        #2 check("rd_rvalid_one_cycle", 32'(m0_if.rvalid), 32'h0);
        check("rd_rdata_hold", m0_if.rdata, 32'hDEADBEEF);

        // Byte-lane merge from m1.
        tick(); set_m1(1'b1, 1'b1, 32'h30, 4'hF, 32'h11223344);
        tick(); set_m1(1'b1, 1'b1, 32'h30, 4'b0010, 32'h0000AB00);
        tick(); set_m1(1'b1, 1'b0, 32'h30, 4'hF, '0);
        tick(); idle();
        #2 check("lane_rvalid", 32'(m1_if.rvalid), 32'h1);
        check("lane_rdata", m1_if.rdata, 32'h1122AB44);

        // Back-to-back reads.
        tick(); set_m0(1'b1, 1'b1, 32'h40, 4'hF, 32'hCAFE0040);
        tick(); set_m0(1'b1, 1'b1, 32'h44, 4'hF, 32'hBEEF0044);
        tick(); set_m0(1'b1, 1'b0, 32'h40, 4'hF, '0);
        tick(); set_m0(1'b1, 1'b0, 32'h44, 4'hF, '0);
        #2 check("b2b_rvalid_a", 32'(m0_if.rvalid), 32'h1);
        check("b2b_rdata_a", m0_if.rdata, 32'hCAFE0040);
        tick(); idle();
        #2 check("b2b_rvalid_b", 32'(m0_if.rvalid), 32'h1);
        check("b2b_rdata_b", m0_if.rdata, 32'hBEEF0044);
        tick();
        #2 check("b2b_rvalid_end", 32'(m0_if.rvalid), 32'h0);

        // Continuous contention: m0 x4 then m1, repeating.
        for (int i = 0; i < 10; i++) begin
            tick();
            set_m0(1'b1, 1'b0, 32'h20, 4'hF, '0);
            set_m1(1'b1, 1'b0, 32'h30, 4'hF, '0);
            #2 check($sformatf("cont_m0_gnt[%0d]", i), 32'(m0_if.gnt), 32'(exp_cont[i]));
            check($sformatf("cont_m1_gnt[%0d]", i), 32'(m1_if.gnt), 32'(!exp_cont[i]));
            check($sformatf("cont_stall[%0d]", i), 32'(m0_if.stall), 32'(!exp_cont[i]));
        end
        tick(); idle();

        // m1 drops out of a starvation run, then contends again from a cleared count.
        for (int i = 0; i < 13; i++) begin
            tick();
            set_m0(1'b1, 1'b0, 32'h40, 4'hF, '0);
            if (i < 2 || i >= 8) set_m1(1'b1, 1'b0, 32'h30, 4'hF, '0);
            else                 set_m1(1'b0, 1'b0, '0, '0, '0);
            #2 check($sformatf("drop_m0_gnt[%0d]", i), 32'(m0_if.gnt), 32'(exp_drop[i]));
            if (i == 2) check("drop_starve_before_clear", 32'(dbg.starve_cnt), 32'd2);
            if (i > 2 && i < 8) check($sformatf("drop_starve[%0d]", i), 32'(dbg.starve_cnt), 32'd0);
        end
        tick(); idle();

        // Random two-master traffic; masters hold an access until granted or drop it.
        busy0 = 1'b0; busy1 = 1'b0; got0 = 1'b0; got1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (!busy0 || got0) begin
                busy0 = ($urandom_range(0, 99) < 65);
                set_m0(busy0, 1'($urandom_range(0, 1)), {22'b0, 8'($urandom_range(0, 31)), 2'b00},
                       4'($urandom_range(0, 15)), $urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                busy0 = 1'b0;
                set_m0(1'b0, 1'b0, '0, '0, '0);
            end
            if (!busy1 || got1) begin
                busy1 = ($urandom_range(0, 99) < 70);
                set_m1(busy1, 1'($urandom_range(0, 1)), {22'b0, 8'($urandom_range(0, 31)), 2'b00},
                       4'($urandom_range(0, 15)), $urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                busy1 = 1'b0;
                set_m1(1'b0, 1'b0, '0, '0, '0);
            end
            #2;
            got0 = m0_if.gnt;
            got1 = m1_if.gnt;
        end

        tick(); idle();
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
